// File: rtl/settle_monitor_if.sv
// Measurement bus between a stimulus/checker (master) and settle_monitor (slave).
// Carries the arm controls, the sample stream and the measurement results.
interface settle_monitor_if #(
    parameter int WIDTH = 18,
    parameter int CNT_W = 24
);
    logic             start;
    logic             v_valid;
    logic [WIDTH-1:0] v_in;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] tol;
    logic [CNT_W-1:0] hold_n;
    logic             busy;
    logic             done;
    logic             settled;
    logic [CNT_W-1:0] settle_time;
    logic [WIDTH-1:0] v_max;
    logic [WIDTH-1:0] v_min;

    modport master (
        output start, v_valid, v_in, target, tol, hold_n,
        input  busy, done, settled, settle_time, v_max, v_min
    );

    modport slave (
        input  start, v_valid, v_in, target, tol, hold_n,
        output busy, done, settled, settle_time, v_max, v_min
    );
endinterface

// File: rtl/settle_monitor.sv
// Settling detector for a fixed-point net: done pulses 1 clk after the deciding sample; no backpressure.
// Every v_valid sample is consumed; SETTLE_MONITOR_PEAK_EN adds signed v_max/v_min peak tracking.
module settle_monitor #(
    parameter int WIDTH       = 18,
    parameter int CNT_W       = 24,
    parameter int MAX_SAMPLES = 1000000
) (
    input  logic           clk,
    input  logic           rst_n,
    settle_monitor_if.slave mon
);
    typedef enum logic [1:0] {IDLE, TRACK, DONE_OK, DONE_TO} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_SAMPLES - 1);
    localparam logic [CNT_W-1:0] TO_TIME  = CNT_W'(MAX_SAMPLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] tol_q, tol_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] run_start_q, run_start_d;
    logic             settled_q, settled_d;
    logic [CNT_W-1:0] settle_time_q, settle_time_d;

    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   err;
    logic             in_band;
    logic [CNT_W-1:0] run_inc;
    logic [CNT_W-1:0] first_idx;

    // One extra bit keeps full-scale opposite-sign differences from wrapping.
    assign diff    = {mon.v_in[WIDTH-1], mon.v_in} - {target_q[WIDTH-1], target_q};
    assign err     = diff[WIDTH] ? (~diff + {{WIDTH{1'b0}}, 1'b1}) : diff;
    assign in_band = (err <= {1'b0, tol_q});
    assign run_inc   = run_q + ONE;
    assign first_idx = (run_q == '0) ? idx_q : run_start_q;

    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        tol_d         = tol_q;
        hold_d        = hold_q;
        idx_d         = idx_q;
        run_d         = run_q;
        run_start_d   = run_start_q;
        settled_d     = settled_q;
        settle_time_d = settle_time_q;

        if (mon.start) begin
            state_d       = TRACK;
            target_d      = mon.target;
            tol_d         = mon.tol;
            hold_d        = (mon.hold_n == '0) ? ONE : mon.hold_n;
            idx_d         = '0;
            run_d         = '0;
            run_start_d   = '0;
            settled_d     = 1'b0;
            settle_time_d = '0;
        end else begin
            case (state_q)
                TRACK: begin
                    if (mon.v_valid) begin
                        idx_d = idx_q + ONE;
                        if (in_band) begin
                            run_d       = run_inc;
                            run_start_d = first_idx;
                        end else begin
                            run_d = '0;
                        end
                        // Settling on the last allowed sample beats the timeout.
                        if (in_band && (run_inc >= hold_q)) begin
                            state_d       = DONE_OK;
                            settled_d     = 1'b1;
                            settle_time_d = first_idx;
                        end else if (idx_q == LAST_IDX) begin
                            state_d       = DONE_TO;
                            settled_d     = 1'b0;
                            settle_time_d = TO_TIME;
                        end
                    end
                end
                DONE_OK, DONE_TO: state_d = IDLE;
                default:          state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            target_q      <= '0;
            tol_q         <= '0;
            hold_q        <= '0;
            idx_q         <= '0;
            run_q         <= '0;
            run_start_q   <= '0;
            settled_q     <= 1'b0;
            settle_time_q <= '0;
        end else begin
            state_q       <= state_d;
            target_q      <= target_d;
            tol_q         <= tol_d;
            hold_q        <= hold_d;
            idx_q         <= idx_d;
            run_q         <= run_d;
            run_start_q   <= run_start_d;
            settled_q     <= settled_d;
            settle_time_q <= settle_time_d;
        end
    end

    assign mon.busy        = (state_q == TRACK);
    assign mon.done        = (state_q == DONE_OK) || (state_q == DONE_TO);
    assign mon.settled     = settled_q;
    assign mon.settle_time = settle_time_q;

`ifdef SETTLE_MONITOR_PEAK_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    logic [WIDTH-1:0] v_max_q, v_max_d;
    logic [WIDTH-1:0] v_min_q, v_min_d;

    always_comb begin
        v_max_d = v_max_q;
        v_min_d = v_min_q;
        if (mon.start) begin
            v_max_d = MOST_NEG;
            v_min_d = MOST_POS;
        end else if ((state_q == TRACK) && mon.v_valid) begin
            if ($signed(mon.v_in) > $signed(v_max_q)) v_max_d = mon.v_in;
            if ($signed(mon.v_in) < $signed(v_min_q)) v_min_d = mon.v_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_max_q <= MOST_NEG;
            v_min_q <= MOST_POS;
        end else begin
            v_max_q <= v_max_d;
            v_min_q <= v_min_d;
        end
    end

    assign mon.v_max = v_max_q;
    assign mon.v_min = v_min_q;
`else
    assign mon.v_max = '0;
    assign mon.v_min = '0;
`endif
endmodule

// File: tb/tb_settle_monitor.sv
// Directed bench for settle_monitor: stimulus queues expected results, a done-driven monitor checks them.
module tb_settle_monitor;
    localparam int W  = 18;
    localparam int C  = 24;
    localparam int MS = 16;
`ifdef SETTLE_MONITOR_PEAK_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    settle_monitor_if #(.WIDTH(W), .CNT_W(C)) bus ();

    settle_monitor #(.WIDTH(W), .CNT_W(C), .MAX_SAMPLES(MS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mon   (bus)
    );

    typedef struct {
        logic         settled;
        logic [C-1:0] st;
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        int           cyc;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    bit   pend_vld = 1'b0;
    int   errs   = 0;
    int   checks = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done === 1'b1) begin
            chk("done_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("done_latency", 32'(cyc), 32'(e.cyc));
                chk("settled", 32'(bus.settled), 32'(e.settled));
                chk("settle_time", 32'(bus.settle_time), 32'(e.st));
                chk("v_max", 32'(bus.v_max), 32'(e.mx));
                chk("v_min", 32'(bus.v_min), 32'(e.mn));
            end
        end
    end

    task automatic push_exp(input bit s, input int st, input int mx, input int mn);
        pend.settled = s;
        pend.st      = C'(st);
        pend.mx      = PK ? W'(mx) : '0;
        pend.mn      = PK ? W'(mn) : '0;
        pend_vld     = 1'b1;
    endtask

    task automatic arm(input int t, input int tl, input int h);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.v_valid = 1'b0;
        bus.target  = W'(t);
        bus.tol     = W'(tl);
        bus.hold_n  = C'(h);
    endtask

    task automatic sample(input int v);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.v_valid = 1'b1;
        bus.v_in    = W'(v);
        if (pend_vld) begin
            pend.cyc = cyc + 1;
            q.push_back(pend);
            pend_vld = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.v_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        chk(name, 32'(q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1[7];
        s1 = '{0, 500, 995, 1012, 1005, 1000, 998};
        bus.start = 1'b0; bus.v_valid = 1'b0; bus.v_in = '0;
        bus.target = '0; bus.tol = '0; bus.hold_n = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_settled", 32'(bus.settled), 0);
        chk("rst_settle_time", 32'(bus.settle_time), 0);
        chk("rst_v_max", 32'(bus.v_max), PK ? 32'h20000 : 0);
        chk("rst_v_min", 32'(bus.v_min), PK ? 32'h1FFFF : 0);
        rst_n = 1'b1;

        // Settle with an interrupted in-band run.
        arm(1000, 10, 3);
        for (int i = 0; i < 7; i++) begin
            if (i == 6) push_exp(1, 4, 1012, 0);
            sample(s1[i]);
            if (i == 0) chk("busy_track", 32'(bus.busy), 1);
        end
        idle(1);
        drain("drain_settle");
        chk("busy_after_done", 32'(bus.busy), 0);

        // Timeout after exactly MS samples.
        arm(1000, 10, 3);
        for (int i = 0; i < MS; i++) begin
            if (i == MS - 1) push_exp(0, MS, 0, 0);
            sample(0);
        end
        idle(1);
        drain("drain_timeout");

        // Exact match with gaps between samples.
        arm(7, 0, 2);
        sample(7); idle(1);
        push_exp(1, 0, 7, 7); sample(7);
        idle(1);
        drain("drain_gap");

        arm(7, 0, 2);
        sample(6); idle(1); sample(7); idle(2);
        push_exp(1, 1, 7, 6); sample(7);
        idle(1);
        drain("drain_gap_idx");

        // hold_n of zero behaves like one.
        arm(50, 0, 0);
        sample(49);
        push_exp(1, 1, 50, 49); sample(50);
        idle(1);
        drain("drain_hold0");

        // Full-scale opposite signs must not wrap into the band.
        arm(-131072, 5, 1);
        for (int i = 0; i < MS; i++) begin
            if (i == MS - 1) push_exp(0, MS, 131071, 131071);
            sample(131071);
        end
        idle(1);
        drain("drain_nowrap");
        arm(-131072, 5, 1);
        push_exp(1, 0, -131070, -131070); sample(-131070);
        idle(1);
        drain("drain_nowrap_ok");

        // Restart mid-run clears counters and suppresses done.
        arm(100, 0, 10);
        repeat (5) sample(100);
        arm(100, 0, 2);
        sample(0); sample(100);
        push_exp(1, 1, 100, 0); sample(100);
        idle(1);
        drain("drain_restart");

        // Start coinciding with the deciding sample wins.
        arm(100, 0, 1);
        @(negedge clk);
        bus.start = 1'b1; bus.v_valid = 1'b1; bus.v_in = W'(100);
        push_exp(1, 0, 100, 100); sample(100);
        idle(1);
        drain("drain_same_cycle");

        // Asynchronous reset aborts a measurement.
        arm(0, 0, 5);
        sample(0); sample(0);
        @(negedge clk);
        rst_n = 1'b0;
        bus.v_valid = 1'b0;
        #1;
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_settled", 32'(bus.settled), 0);
        chk("arst_done", 32'(bus.done), 0);
        idle(2);
        rst_n = 1'b1;
        idle(2);
        chk("post_arst_busy", 32'(bus.busy), 0);

        // Peak tracking.
        arm(1000, 0, 1);
        sample(0); sample(1200); sample(-300);
        push_exp(1, 3, 1200, -300); sample(1000);
        idle(1);
        drain("drain_peaks");

        idle(3);
        chk("queue_empty", 32'(q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
